// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffers.
//   pipe_state_t : occupancy state of a stage (EMPTY / ONE / TWO)
//   PIPE_NOP     : bubble word, the NOP encoding with all control bits clear
//   *_WIDTH      : payload widths of the four CPU pipeline boundaries
//   occ_of()     : entry count for a state
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

  localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

  localparam int IF_ID_WIDTH  = 64;
  localparam int ID_EX_WIDTH  = 148;
  localparam int EX_MEM_WIDTH = 107;
  localparam int MEM_WB_WIDTH = 71;

  function automatic logic [1:0] occ_of(input pipe_state_t s);
    case (s)
      ST_ONE:  occ_of = 2'd1;
      ST_TWO:  occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, stall back-pressure,
// synchronous flush and an optional two-entry skid buffer.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous reset, active-high
//   valid_i  in   upstream word present on data_i
//   ready_o  out  stage accepts a word this cycle
//   data_i   in   upstream payload
//   flush_i  in   synchronous flush; empties the stage, drops the input word
//   valid_o  out  data_o holds a live word
//   ready_i  in   downstream accepts this cycle
//   data_o   out  payload to next stage (BUBBLE when valid_o=0)
//   occ_o    out  number of entries held (0..2)
//
// state    | meaning
// ST_EMPTY | no word held, data_o shows BUBBLE
// ST_ONE   | one word in main register
// ST_TWO   | main plus one absorbed word in skid register (SKID=1 only)
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter bit               SKID   = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       occ_o
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_xfer, out_xfer;

  assign valid_o  = (state_q != ST_EMPTY);
  assign data_o   = main_q;
  assign occ_o    = occ_of(state_q);
  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_ONE;
            main_d  = data_i;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = data_i;
          end else if (in_xfer && SKID) begin
            // Downstream stalled: park the new word behind the current one.
            state_d = ST_TWO;
            skid_d  = data_i;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
          end
        end
        ST_TWO: begin
          // ready_o is low here, so no input can arrive in this state.
          if (out_xfer) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      // Registered ready breaks the combinational path from the hazard unit
      // back through every upstream stage; the skid entry covers the one
      // word that can arrive in the cycle the stall is first seen.
      logic ready_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ready_q <= 1'b1;
        else       ready_q <= (state_d != ST_TWO);
      end
      assign ready_o = ready_q;
    end else begin : g_single
      assign ready_o = !valid_o | ready_i;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, flush_i, ready_i;
  logic [31:0] data_i;

  logic        r1, v1, r0, v0;
  logic [31:0] d1, d0;
  logic [1:0]  o1, o0;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] BUB0 = 32'hFFFF_FFFF;
  localparam logic [31:0] BUB1 = 32'h0000_0000;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(32), .BUBBLE(BUB1), .SKID(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(r1),
    .data_i(data_i), .flush_i(flush_i), .valid_o(v1), .ready_i(ready_i),
    .data_o(d1), .occ_o(o1)
  );

  pipe_stage_buf #(.WIDTH(32), .BUBBLE(BUB0), .SKID(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(r0),
    .data_i(data_i), .flush_i(flush_i), .valid_o(v0), .ready_i(ready_i),
    .data_o(d0), .occ_o(o0)
  );

  // Reference model: each stage is a FIFO of live words.
  logic [31:0] q1[$];
  logic [31:0] q0[$];
  logic        m1_ready;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        f;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  eo;
    logic        er;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    data_i  = 32'h0;
    q1.delete();
    q0.delete();
    m1_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
  endtask

  initial begin
    logic in1, out1, in0, out0;
    logic [31:0] e1, e0;

    // --- reset state ---
    do_reset();
    check("rst_valid1", {63'b0, v1}, 64'd0);
    check("rst_data1",  {32'b0, d1}, {32'b0, BUB1});
    check("rst_occ1",   {62'b0, o1}, 64'd0);
    check("rst_ready1", {63'b0, r1}, 64'd1);
    check("rst_data0",  {32'b0, d0}, {32'b0, BUB0});
    check("rst_ready0", {63'b0, r0}, 64'd1);

    // --- streaming, stall absorb, flush priority on the SKID=1 stage ---
    tbl[0]  = '{1'b1, 32'h1,    1'b1, 1'b0, 1'b1, 32'h1,    2'd1, 1'b1};
    tbl[1]  = '{1'b1, 32'h2,    1'b1, 1'b0, 1'b1, 32'h2,    2'd1, 1'b1};
    tbl[2]  = '{1'b1, 32'h3,    1'b1, 1'b0, 1'b1, 32'h3,    2'd1, 1'b1};
    tbl[3]  = '{1'b1, 32'h4,    1'b1, 1'b0, 1'b1, 32'h4,    2'd1, 1'b1};
    tbl[4]  = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, BUB1,     2'd0, 1'b1};
    tbl[5]  = '{1'b1, 32'hA,    1'b1, 1'b0, 1'b1, 32'hA,    2'd1, 1'b1};
    tbl[6]  = '{1'b1, 32'hB,    1'b0, 1'b0, 1'b1, 32'hA,    2'd2, 1'b0};
    tbl[7]  = '{1'b1, 32'hC,    1'b0, 1'b0, 1'b1, 32'hA,    2'd2, 1'b0};
    tbl[8]  = '{1'b1, 32'hC,    1'b1, 1'b0, 1'b1, 32'hB,    2'd1, 1'b1};
    tbl[9]  = '{1'b1, 32'hC,    1'b1, 1'b0, 1'b1, 32'hC,    2'd1, 1'b1};
    tbl[10] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, BUB1,     2'd0, 1'b1};
    tbl[11] = '{1'b1, 32'h1111, 1'b0, 1'b0, 1'b1, 32'h1111, 2'd1, 1'b1};
    tbl[12] = '{1'b1, 32'h2222, 1'b0, 1'b0, 1'b1, 32'h1111, 2'd2, 1'b0};
    tbl[13] = '{1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0, BUB1,     2'd0, 1'b1};
    tbl[14] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, BUB1,     2'd0, 1'b1};

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), {63'b0, v1}, {63'b0, tbl[i].ev});
      check($sformatf("vec%0d_data", i),  {32'b0, d1}, {32'b0, tbl[i].ed});
      check($sformatf("vec%0d_occ", i),   {62'b0, o1}, {62'b0, tbl[i].eo});
      check($sformatf("vec%0d_ready", i), {63'b0, r1}, {63'b0, tbl[i].er});
    end

    // --- asynchronous reset while holding two words ---
    do_reset();
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 32'h88, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("arst_pre_occ", {62'b0, o1}, 64'd2);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {63'b0, v1}, 64'd0);
    check("arst_data",  {32'b0, d1}, {32'b0, BUB1});
    check("arst_occ",   {62'b0, o1}, 64'd0);
    check("arst_ready", {63'b0, r1}, 64'd1);
    check("arst_data0", {32'b0, d0}, {32'b0, BUB0});
    @(negedge clk);
    rst = 1'b0;

    // --- SKID=0 with all-ones bubble: combinational ready, drain ---
    do_reset();
    drive(1'b1, 32'h5, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("s0_valid", {63'b0, v0}, 64'd1);
    check("s0_data",  {32'b0, d0}, 64'h5);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("s0_ready_stall", {63'b0, r0}, 64'd0);
    ready_i = 1'b1;
    #1;
    check("s0_ready_go", {63'b0, r0}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("s0_drain_valid", {63'b0, v0}, 64'd0);
    check("s0_drain_data",  {32'b0, d0}, {32'b0, BUB0});

    // --- randomized run against FIFO model, both stage variants ---
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      e1 = (q1.size() > 0) ? q1[0] : BUB1;
      e0 = (q0.size() > 0) ? q0[0] : BUB0;
      check("rnd_valid1", {63'b0, v1}, {63'b0, q1.size() > 0});
      check("rnd_data1",  {32'b0, d1}, {32'b0, e1});
      check("rnd_occ1",   {62'b0, o1}, 64'(q1.size()));
      check("rnd_ready1", {63'b0, r1}, {63'b0, m1_ready});
      check("rnd_valid0", {63'b0, v0}, {63'b0, q0.size() > 0});
      check("rnd_data0",  {32'b0, d0}, {32'b0, e0});
      check("rnd_occ0",   {62'b0, o0}, 64'(q0.size()));

      drive($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 4);
      #1;
      check("rnd_ready0", {63'b0, r0}, {63'b0, (q0.size() == 0) || ready_i});

      in1  = valid_i && m1_ready;
      out1 = (q1.size() > 0) && ready_i;
      in0  = valid_i && ((q0.size() == 0) || ready_i);
      out0 = (q0.size() > 0) && ready_i;

      @(posedge clk);
      if (flush_i) begin
        q1.delete();
        q0.delete();
      end else begin
        if (out1) void'(q1.pop_front());
        if (in1)  q1.push_back(data_i);
        if (out0) void'(q0.pop_front());
        if (in0)  q0.push_back(data_i);
      end
      m1_ready = (q1.size() < 2);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register for the pipelined CPU, replacing the fixed plain stage register between IF/ID, ID/EX, EX/MEM and MEM/WB. Adds a valid/ready handshake, stall back-pressure, synchronous flush with bubble insertion, and an optional two-entry skid mode that registers `ready_o`, so hazard stalls no longer form long combinational ready paths. When a stage is empty it presents a configurable bubble word, normally the NOP encoding with all control bits clear.

## Interface
- `WIDTH`, 32: payload width in bits, ≥1.
- `BUBBLE`, `{WIDTH{1'b0}}`: value driven on `data_o` whenever `valid_o`=0.
- `SKID`, 1: 1 gives two-entry skid buffer with registered `ready_o`; 0 gives single entry with combinational `ready_o`.

Ports:
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_i`  in  1  asynchronous reset, active-high.
- `valid_i`  in  1  upstream has a word on `data_i`.
- `ready_o`  out  1  stage can accept a word this cycle.
- `data_i`  in  WIDTH  upstream payload.
- `flush_i`  in  1  synchronous flush, for example on a taken branch.
- `valid_o`  out  1  `data_o` holds a live word.
- `ready_i`  in  1  downstream accepts this cycle (0 = stall).
- `data_o`  out  WIDTH  payload to the next stage.
- `occ_o`  out  2  number of entries held: 0, 1 or 2.

## Operation
- Input transfer happens when `valid_i & ready_o`. Output transfer happens when `valid_o & ready_i`.
- Internal state: main register (drives `data_o`), skid register, and state EMPTY / ONE / TWO. TWO exists only when SKID=1.
- `valid_o` = (state ≠ EMPTY). `occ_o` = 0 / 1 / 2 for EMPTY / ONE / TWO.
- SKID=1: `ready_o` is a register equal to (next state ≠ TWO).
- SKID=0: `ready_o` = `!valid_o | ready_i`, combinational.
- State transitions when `flush_i`=0:
  - EMPTY, in → ONE; main ← `data_i`.
  - ONE, in & !out → TWO; skid ← `data_i`; main holds.
  - ONE, in & out → ONE; main ← `data_i`.
  - ONE, out & !in → EMPTY; main ← `BUBBLE`.
  - TWO, out → ONE; main ← skid. No input can occur because `ready_o`=0.
  - Any state, no transfer → hold.
- Flush: `flush_i`=1 forces the next state to EMPTY and main ← `BUBBLE`. Flush has priority over a simultaneous input or output transfer, and the input word in that cycle is discarded. Upstream sees a handshake, so the word is dropped by design. Flush with SKID=1 sets `ready_o` to 1 on the next cycle.
- Invariant: `data_o` == `BUBBLE` whenever `valid_o`=0.
- Data ordering is strictly FIFO. No word is duplicated or lost except by flush.

## Timing
- Reset (asynchronous, immediate): state EMPTY, `valid_o`=0, `data_o`=`BUBBLE`, `occ_o`=0, `ready_o`=1, skid register = `BUBBLE`.
- Release of `rst_i` is synchronised upstream by the top level. The block needs no deassertion handling.
- Latency: 1 cycle from an input transfer to `valid_o` when the stage was empty or draining.
- Throughput: 1 word per cycle while `ready_i`=1.
- SKID=1: with `ready_i` dropping the same cycle as an input, one extra word is absorbed. `ready_o` falls the following cycle.
- SKID=1: with `ready_i` held low, at most 2 words are held. `ready_o` rises the cycle after the first output transfer from TWO.
- Reset asserted mid-operation discards all contents. Outputs take their reset values within the reset assertion, without waiting for a clock edge.

## Structure
- Shared package `pipe_pkg`:
  - state enum `pipe_state_t` (EMPTY, ONE, TWO);
  - `PIPE_NOP` constant (32'h0000_0000);
  - per-boundary width constants: IF/ID 64, ID/EX 148, EX/MEM 107, MEM/WB 71.
- Single leaf module with no sub-modules. SKID=0 / SKID=1 are selected with a generate branch.
- The CPU top instantiates four copies. The hazard unit drives `ready_i` / `flush_i`.

## Test plan
- Streaming, WIDTH=32, SKID=1: valid_i=1 with data 1,2,3,4 and ready_i=1 → data_o shows 1,2,3,4 on consecutive cycles, one cycle later; occ_o stays 1.
- Stall absorb: feed 0xA, 0xB, 0xC; set ready_i=0 the cycle 0xB is presented → occ_o=2 and ready_o=0; 0xC is held off upstream. After ready_i=1, outputs are 0xA, 0xB, 0xC in order with no loss.
- Flush priority: in state TWO, assert flush_i with valid_i=1 and data 0xDEAD → next cycle valid_o=0, data_o=BUBBLE, occ_o=0, ready_o=1; 0xDEAD never appears.
- Asynchronous reset: assert rst_i between clock edges while occ_o=2 → valid_o=0, data_o=BUBBLE, ready_o=1 before the next edge.
- SKID=0, BUBBLE=32'hFFFF_FFFF: ready_i=0 with valid_o=1 → ready_o=0 in the same cycle. Drain with no new input → data_o=32'hFFFF_FFFF and valid_o=0.
- Random valid_i / ready_i / flush_i for 10k cycles against a scoreboard → order preserved, BUBBLE invariant holds, occ_o ≤ 2 (≤ 1 when SKID=0).
